// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and reset defaults for the multi-channel PWM.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_CNT_W_DEFAULT = 16;
    localparam int c_DEF_PERIOD    = 4999;
    localparam int c_DEF_DUTY      = 2500;

    typedef logic [c_CNT_W_DEFAULT-1:0] cnt_t;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

endpackage
`default_nettype wire

// File: rtl/pwm_ch_cmp.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ch_cmp
// Description : One PWM channel: active duty register, comparator, output flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ch_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W_DEFAULT,
    parameter int DEF_DUTY = c_DEF_DUTY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_duty_sh,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_period,
    input  pwm_mode_e        i_mode,
    output logic             o_pwm
);

    localparam logic [CNT_W-1:0] c_DEF_DTY = CNT_W'(DEF_DUTY);
    localparam logic [CNT_W:0]   c_ONE_EXT = (CNT_W+1)'(1);

    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] w_duty;
    logic             w_full;
    logic             w_raw;
    logic             r_pwm;

    // The counter value at a boundary already belongs to the new period,
    // so it is compared against the duty being loaded, not the stale one.
    assign w_duty = i_load ? i_duty_sh : r_duty_act;

    assign w_full = (i_mode == PWM_EDGE)
                  ? ({1'b0, w_duty} >= ({1'b0, i_period} + c_ONE_EXT))
                  : (w_duty > i_period);

    assign w_raw = w_full || (i_cnt < w_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_act <= c_DEF_DTY;
            r_pwm      <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty_act <= i_duty_sh;
            end
            r_pwm <= i_enable && w_raw;
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : Shared period counter driving NUM_CH duty comparators with
//               boundary-synchronised shadow configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W_DEFAULT,
    parameter int NUM_CH     = 4,
    parameter int DEF_PERIOD = c_DEF_PERIOD,
    parameter int DEF_DUTY   = c_DEF_DUTY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        period_in,
    input  logic [NUM_CH*CNT_W-1:0] duty_in,
    input  logic                    center_mode,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick,
    output logic [CNT_W-1:0]        cnt_out
);

    localparam logic [CNT_W-1:0] c_DEF_PER = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] c_DEF_DTY = CNT_W'(DEF_DUTY);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_dir_up;
    logic                    r_tick;
    logic [CNT_W-1:0]        r_per_sh;
    logic [CNT_W-1:0]        r_per_act;
    pwm_mode_e               r_mode_sh;
    pwm_mode_e               r_mode_act;
    logic [NUM_CH*CNT_W-1:0] r_duty_sh;

    logic                    w_boundary;
    logic [CNT_W-1:0]        w_per_eff;
    pwm_mode_e               w_mode_eff;

    // The counter is held at 0 while disabled, so the first enabled cycle
    // is automatically a boundary and picks up the latest shadow values.
    assign w_boundary = enable && (r_cnt == '0);
    assign w_per_eff  = w_boundary ? r_per_sh  : r_per_act;
    assign w_mode_eff = w_boundary ? r_mode_sh : r_mode_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_sh  <= c_DEF_PER;
            r_mode_sh <= PWM_EDGE;
            r_duty_sh <= {NUM_CH{c_DEF_DTY}};
        end else if (cfg_load) begin
            r_per_sh  <= period_in;
            r_mode_sh <= center_mode ? PWM_CENTER : PWM_EDGE;
            r_duty_sh <= duty_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_act  <= c_DEF_PER;
            r_mode_act <= PWM_EDGE;
        end else if (w_boundary) begin
            r_per_act  <= r_per_sh;
            r_mode_act <= r_mode_sh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_boundary;
            if (!enable) begin
                r_cnt    <= '0;
                r_dir_up <= 1'b1;
            end else if (w_boundary) begin
                r_cnt    <= (w_per_eff == '0) ? '0 : c_ONE;
                r_dir_up <= 1'b1;
            end else if (w_mode_eff == PWM_EDGE) begin
                r_cnt <= (r_cnt >= w_per_eff) ? '0 : (r_cnt + c_ONE);
            end else if (r_dir_up) begin
                if (r_cnt >= w_per_eff) begin
                    r_dir_up <= 1'b0;
                    r_cnt    <= r_cnt - c_ONE;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                // Reaching 0 on the way down makes the next cycle a boundary,
                // which turns the direction back to up.
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            pwm_ch_cmp #(
                .CNT_W    (CNT_W),
                .DEF_DUTY (DEF_DUTY)
            ) u_cmp (
                .clk       (clk),
                .rst       (rst),
                .i_enable  (enable),
                .i_load    (w_boundary),
                .i_duty_sh (r_duty_sh[k*CNT_W +: CNT_W]),
                .i_cnt     (r_cnt),
                .i_period  (w_per_eff),
                .i_mode    (w_mode_eff),
                .o_pwm     (pwm_out[k])
            );
        end
    endgenerate

    assign period_tick = r_tick;
    assign cnt_out     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pwm_multi_gen
// Description : Scoreboard bench for pwm_multi_gen with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cfg_load = 1'b0;
    logic        center_mode = 1'b0;
    logic [15:0] period_in = '0;
    logic [63:0] duty_in = '0;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic [15:0] cnt_out;

    typedef struct {
        int          ph;
        logic [15:0] cnt;
        logic [3:0]  pwm;
        logic        tick;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cseq[8];
    int          d0;

    pwm_multi_gen #(
        .CNT_W      (16),
        .NUM_CH     (4),
        .DEF_PERIOD (4999),
        .DEF_DUTY   (2500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .center_mode (center_mode),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .cnt_out     (cnt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cmp4(input int c, input int a, input int b,
                                        input int x, input int y);
        return {c < y, c < x, c < b, c < a};
    endfunction

    task automatic push(input int ph, input int c, input logic [3:0] p, input logic t);
        exp_t e;
        e.ph   = ph;
        e.cnt  = 16'(c);
        e.pwm  = p;
        e.tick = t;
        q.push_back(e);
    endtask

    task automatic cyc(input int ph, input int c, input logic [3:0] p, input logic t);
        @(posedge clk);
        #2;
        push(ph, c, p, t);
    endtask

    task automatic cfg(input int per, input int a, input int b, input int x,
                       input int y, input logic cm);
        period_in   = 16'(per);
        duty_in     = {16'(y), 16'(x), 16'(b), 16'(a)};
        center_mode = cm;
    endtask

    // Monitor: compares every queued expectation half a cycle after its edge.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                m = q.pop_front();
                checks++;
                if (cnt_out !== m.cnt) begin
                    errors++;
                    $display("FAIL ph%0d cnt_out: got %0d expected %0d", m.ph, cnt_out, m.cnt);
                end
                checks++;
                if (pwm_out !== m.pwm) begin
                    errors++;
                    $display("FAIL ph%0d pwm_out: got %b expected %b (cnt %0d)", m.ph, pwm_out, m.pwm, cnt_out);
                end
                checks++;
                if (period_tick !== m.tick) begin
                    errors++;
                    $display("FAIL ph%0d period_tick: got %b expected %b (cnt %0d)", m.ph, period_tick, m.tick, cnt_out);
                end
            end
        end
    end

    initial begin
        cseq = '{0, 1, 2, 3, 4, 3, 2, 1};

        // Reset state, then release between edges with defaults running
        cyc(0, 0, 4'h0, 1'b0);
        cyc(0, 0, 4'h0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 10000; k++)
            cyc(1, k % 5000, (((k - 1) % 5000) < 2500) ? 4'hF : 4'h0, ((k - 1) % 5000) == 0);

        // Edge mode P=9, duties 3/0/10/5
        cfg(9, 3, 0, 10, 5, 1'b0);
        enable   = 1'b0;
        cfg_load = 1'b1;
        cyc(2, 0, 4'h0, 1'b0);
        cfg_load = 1'b0;
        enable   = 1'b1;
        for (int k = 1; k <= 30; k++)
            cyc(2, k % 10, cmp4((k - 1) % 10, 3, 0, 10, 5), ((k - 1) % 10) == 0);

        // Shadow timing: load mid-period (cnt=4) and exactly at a boundary
        for (int k = 31; k <= 70; k++) begin
            cfg_load = (k == 35) || (k == 51);
            if (k == 35) cfg(9, 7, 0, 10, 5, 1'b0);
            else if (k == 51) cfg(9, 2, 0, 10, 5, 1'b0);
            d0 = (k <= 40) ? 3 : ((k <= 60) ? 7 : 2);
            cyc(3, k % 10, cmp4((k - 1) % 10, d0, 0, 10, 5), ((k - 1) % 10) == 0);
        end
        cfg_load = 1'b0;

        // Enable drop at cnt=6, shadow write while stopped, restart
        for (int k = 71; k <= 76; k++)
            cyc(4, k % 10, cmp4((k - 1) % 10, 2, 0, 10, 5), ((k - 1) % 10) == 0);
        enable = 1'b0;
        cyc(4, 0, 4'h0, 1'b0);
        cfg(9, 4, 0, 10, 5, 1'b0);
        cfg_load = 1'b1;
        cyc(4, 0, 4'h0, 1'b0);
        cfg_load = 1'b0;
        enable   = 1'b1;
        for (int j = 1; j <= 20; j++)
            cyc(4, j % 10, cmp4((j - 1) % 10, 4, 0, 10, 5), ((j - 1) % 10) == 0);

        // Center mode P=4, duties 2/0/5/1
        enable = 1'b0;
        cfg(4, 2, 0, 5, 1, 1'b1);
        cfg_load = 1'b1;
        cyc(5, 0, 4'h0, 1'b0);
        cfg_load = 1'b0;
        enable   = 1'b1;
        for (int j = 1; j <= 24; j++)
            cyc(5, cseq[j % 8], cmp4(cseq[(j - 1) % 8], 2, 0, 5, 1), ((j - 1) % 8) == 0);

        // Degenerate period P=0, duties 0/1/3/0
        enable = 1'b0;
        cfg(0, 0, 1, 3, 0, 1'b0);
        cfg_load = 1'b1;
        cyc(6, 0, 4'h0, 1'b0);
        cfg_load = 1'b0;
        enable   = 1'b1;
        for (int j = 1; j <= 8; j++)
            cyc(6, 0, 4'b0110, 1'b1);

        // Asynchronous reset between edges clears outputs before the next edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        push(7, 0, 4'h0, 1'b0);
        cyc(7, 0, 4'h0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++)
            cyc(8, k, 4'hF, k == 1);

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator, the successor to the fixed single-channel 5000-cycle / 50% generator. One shared period counter drives NUM_CH independent duty comparators. Period, duty and edge/center alignment are runtime-programmable through shadow registers that take effect only at a period boundary, so there are no glitches. It sits between the control/register logic and the pad drivers of power/LED stages.

Parameters:
CNT_W, 16, width of the period counter, period and duty values
NUM_CH, 4, number of PWM output channels
DEF_PERIOD, 4999, period value loaded at reset (edge mode gives 5000-cycle period)
DEF_DUTY, 2500, duty value loaded into every channel at reset

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  run/stop for the counter and outputs
cfg_load  in  1  single-cycle strobe; captures period_in, duty_in, center_mode into the shadow registers
period_in  in  CNT_W  new period value P
duty_in  in  NUM_CH*CNT_W  new duty values; channel k at bits [k*CNT_W +: CNT_W]
center_mode  in  1  0 = edge-aligned, 1 = center-aligned
pwm_out  out  NUM_CH  registered PWM outputs
period_tick  out  1  one-cycle pulse at the start of each period
cnt_out  out  CNT_W  current counter value, for debug and ADC triggering

Behaviour:
- Reset (async, rst=1):
  - counter=0, direction=up.
  - Shadow and active period = DEF_PERIOD; all duties = DEF_DUTY; mode = edge.
  - pwm_out=0, period_tick=0.
- Register layers:
  - shadow regs: written on any cycle with cfg_load=1.
  - active regs: copied from shadow at each period boundary and on the first enabled cycle after enable rises.
  - cfg_load coincident with a boundary: active takes the OLD shadow; the new values apply at the following boundary.
- Boundary definition: the cycle in which the counter equals 0 while enable=1.
- Edge mode:
  - Counter counts 0,1,...,P, then 0. Period length is P+1 cycles.
- Center mode:
  - Counter counts up 0..P, then down P-1..1, then 0. Period length is 2P cycles for P>=1.
  - Direction flips at P and at 0.
- P=0 (either mode): counter stays 0, a boundary occurs every cycle, and period_tick is held high.
- Compare, per channel, with active duty D:
  - Raw output raw = (counter < D).
  - D=0 gives a constant low output.
  - Edge mode, D>=P+1: constant high. High time is D cycles per period.
  - Center mode: high time is 2D-1 cycles, centred on counter=0. D>P gives constant high.
- Latency:
  - pwm_out[k] and period_tick are registered: each reflects the counter value of the previous cycle (1-cycle latency).
  - cnt_out is the counter register itself.
- Mode change: takes effect only at a boundary; the counter restarts from 0 with direction=up.
- enable=0:
  - Counter forced to 0, direction=up. pwm_out=0 and period_tick=0 from the next cycle.
  - Shadow regs remain writable.
- Arithmetic: all compares are unsigned at CNT_W bits. No overflow is possible because the counter never exceeds P.
- Reset mid-period: all state returns immediately to reset values; no partial pulse completes.

Decomposition:
- Package pwm_pkg holds:
  - typedef cnt_t (logic [CNT_W-1:0]) with a default width constant
  - enum pwm_mode_e {PWM_EDGE, PWM_CENTER}
  - the DEF_PERIOD/DEF_DUTY defaults
- Sub-module pwm_ch_cmp is instantiated NUM_CH times. It holds the active duty register for one channel, plus the comparator and output flop. Ports: clk, rst, enable, load strobe, shadow duty, counter, period, mode.
- The top level holds the counter, direction flop, shadow/active period and mode, and the boundary logic.

Test Plan:
- Reset defaults (CNT_W=16): release rst with enable=1 and no cfg_load -> pwm_out[k] high 2500 cycles then low 2500, period_tick every 5000 cycles.
- Edge mode: P=9, D0=3, D1=0, D2=10, D3=5 -> per 10-cycle period ch0 high 3, ch1 always 0, ch2 always 1, ch3 high 5; period_tick every 10 cycles.
- Center mode: P=4, D0=2 -> counter 0,1,2,3,4,3,2,1 repeating; pwm_out[0] delayed one cycle is 1,1,0,0,0,0,0,1; period_tick every 8 cycles.
- Shadow timing: with P=9, pulse cfg_load with D0=7 at counter=4 -> current period keeps D0=3; next period high 7 cycles. cfg_load exactly at counter=0 -> change is delayed one full period.
- Enable/reset mid-period: drop enable at counter=6 -> pwm_out=0 and cnt_out=0 next cycle; re-enable -> restart at 0 with the latest shadow values. Assert rst asynchronously between clock edges -> outputs 0 immediately.
- Degenerate period P=0 -> cnt_out=0 constantly, period_tick held 1; D=0 gives low output, D>=1 gives high output.
